// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
//   Round-robin arbiter with lock-until-release semantics. When idle, a new owner
//   is chosen from the requests, starting at a rotating pointer. The owner keeps
//   the grant until it pulses done, drops its request, or reaches MAX_HOLD
//   consecutive grant cycles. After every release there is at least one idle
//   cycle, and the pointer moves to the agent after the old owner.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no grant; choose an owner from r, starting at ptr
//   GRANTED | g is one-hot on the latched owner; hold count runs
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset
//   r       in   [AGENTS] level-sensitive requests
//   done    in   [AGENTS] release pulses (only the owner's bit is honoured)
//   g       out  [AGENTS] grant, one-hot or zero
//   busy    out  high while any grant bit is set
//   timeout out  one-cycle pulse after a release forced by the hold limit
module rr_lock_arbiter #(
    parameter int AGENTS   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AGENTS-1:0] r,
    input  logic [AGENTS-1:0] done,
    output logic [AGENTS-1:0] g,
    output logic              busy,
    output logic              timeout
);

    localparam int IDX_W = $clog2(AGENTS);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;

    logic [IDX_W-1:0]   w_pick;
    logic               w_found;
    logic               w_owner_done;
    logic               w_owner_req;
    logic               w_at_limit;
    logic               w_release;

    // Search r starting at ptr and wrap around. The first set bit found wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < AGENTS; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= AGENTS) begin
                idx = idx - AGENTS;
            end
            if (!w_found && r[idx]) begin
                w_pick  = IDX_W'(idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_owner_done = done[r_owner];
    assign w_owner_req  = r[r_owner];
    assign w_at_limit   = (r_count == CNT_W'(MAX_HOLD));
    assign w_release    = w_owner_done | ~w_owner_req | w_at_limit;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_count   <= w_count_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_count_nxt   = r_count;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANTED;
                    w_owner_nxt = w_pick;
                    w_count_nxt = CNT_W'(1);
                end
            end
            ST_GRANTED: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_ptr_nxt   = (r_owner == IDX_W'(AGENTS - 1)) ? '0
                                                                  : r_owner + IDX_W'(1);
                    // A release counts as a timeout only when the hold limit is
                    // the sole cause of it.
                    w_timeout_nxt = w_at_limit & ~w_owner_done & w_owner_req;
                end else begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registers only.
    always_comb begin
        g = '0;
        if (r_state == ST_GRANTED) begin
            g[r_owner] = 1'b1;
        end
        busy    = |g;
        timeout = r_timeout;
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
module tb_rr_lock_arbiter;

    localparam int AGENTS   = 4;
    localparam int MAX_HOLD = 4;

    logic              clock;
    logic              reset;
    logic [AGENTS-1:0] r;
    logic [AGENTS-1:0] done;
    logic [AGENTS-1:0] g;
    logic              busy;
    logic              timeout;

    int n_checks;
    int n_fails;
    bit mon_en;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] dn;
        logic [3:0] exp_g;
        logic       exp_to;
    } vec_t;

    vec_t vecs[$];

    rr_lock_arbiter #(
        .AGENTS  (AGENTS),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .r      (r),
        .done   (done),
        .g      (g),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] dn,
                       input logic [3:0] eg, input logic eto);
        vec_t v;
        v.rst    = rst;
        v.req    = req;
        v.dn     = dn;
        v.exp_g  = eg;
        v.exp_to = eto;
        vecs.push_back(v);
    endtask

    // Drive inputs away from the edge, let one rising edge pass, then check outputs.
    task automatic step(input string name, input logic rst, input logic [3:0] req,
                        input logic [3:0] dn, input logic [3:0] eg, input logic eto);
        @(negedge clock);
        reset = rst;
        r     = req;
        done  = dn;
        @(posedge clock);
        #1;
        n_checks++;
        if (g !== eg) begin
            n_fails++;
            $display("FAIL %s g: got %b want %b", name, g, eg);
        end
        n_checks++;
        if (busy !== (|eg)) begin
            n_fails++;
            $display("FAIL %s busy: got %b want %b", name, busy, |eg);
        end
        n_checks++;
        if (timeout !== eto) begin
            n_fails++;
            $display("FAIL %s timeout: got %b want %b", name, timeout, eto);
        end
    endtask

    // Grant must stay one-hot or zero in every cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            n_checks++;
            if (!$onehot0(g)) begin
                n_fails++;
                $display("FAIL onehot g: got %b want one-hot or zero", g);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        r        = '0;
        done     = '0;

        // Reset held with everything requesting and releasing
        add(1, 4'b1111, 4'b1111, 4'b0000, 0);
        add(1, 4'b1111, 4'b1111, 4'b0000, 0);
        // Full rotation, owner pulses done in its first grant cycle
        add(0, 4'b1111, 4'b0000, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 0);
        add(0, 4'b1111, 4'b0010, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b0100, 0);
        add(0, 4'b1111, 4'b0100, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b1000, 0);
        add(0, 4'b1111, 4'b1000, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0);
        // Owner 0 drops request; then agent 2 alone, done in 3rd grant cycle
        add(0, 4'b0100, 4'b0000, 4'b0000, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 0);
        // Agent 1 alone with no done: hold limit forces release with timeout
        add(0, 4'b0010, 4'b0000, 4'b0000, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, 0);
        add(0, 4'b0010, 4'b0000, 4'b0000, 1);
        add(0, 4'b0010, 4'b0000, 4'b0010, 0);
        // Non-owner done bits ignored, then owner drops its request
        add(0, 4'b1111, 4'b1101, 4'b0010, 0);
        add(0, 4'b1101, 4'b0000, 4'b0000, 0);
        add(0, 4'b1101, 4'b0000, 4'b0100, 0);
        // done coinciding with the hold limit: no timeout
        add(0, 4'b1101, 4'b0000, 4'b0100, 0);
        add(0, 4'b1101, 4'b0000, 4'b0100, 0);
        add(0, 4'b1101, 4'b0000, 4'b0100, 0);
        add(0, 4'b1101, 4'b0100, 4'b0000, 0);
        add(0, 4'b1101, 4'b0000, 4'b1000, 0);
        // Reset mid-grant, then arbitration restarts at agent 0
        add(1, 4'b1101, 4'b0000, 4'b0000, 0);
        add(0, 4'b1001, 4'b0000, 4'b0001, 0);

        mon_en = 1'b1;
        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].dn,
                 vecs[i].exp_g, vecs[i].exp_to);
        end

        // Dropped request coinciding with the hold limit: no timeout
        step("droplim_c2", 0, 4'b0001, 4'b0000, 4'b0001, 0);
        step("droplim_c3", 0, 4'b0001, 4'b0000, 4'b0001, 0);
        step("droplim_c4", 0, 4'b0001, 4'b0000, 4'b0001, 0);
        step("droplim_rel", 0, 4'b0000, 4'b0000, 4'b0000, 0);
        step("idle_stay", 0, 4'b0000, 4'b1111, 4'b0000, 0);

        // Reset on the cycle the limit would fire: no timeout leaks out
        step("rstlim_c1", 0, 4'b0001, 4'b0000, 4'b0001, 0);
        step("rstlim_c2", 0, 4'b0001, 4'b0000, 4'b0001, 0);
        step("rstlim_c3", 0, 4'b0001, 4'b0000, 4'b0001, 0);
        step("rstlim_c4", 0, 4'b0001, 4'b0000, 4'b0001, 0);
        step("rstlim_rst", 1, 4'b0001, 4'b0000, 4'b0000, 0);
        step("rstlim_regrant", 0, 4'b0001, 4'b0000, 4'b0001, 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 The block SHALL have parameter AGENTS, default 8, giving the number of requesters; legal values are 2 or more.
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum number of consecutive grant cycles for one owner; legal values are 1 or more.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port r, input, AGENTS bits: per-agent request, level-sensitive.
REQ-006 The block SHALL have port done, input, AGENTS bits: per-agent release pulse; only the bit of the current owner is honoured.
REQ-007 The block SHALL have port g, output, AGENTS bits: registered grant, one-hot or zero.
REQ-008 The block SHALL have port busy, output, 1 bit: 1 while any grant bit is set.
REQ-009 The block SHALL have port timeout, output, 1 bit: a 1-cycle pulse marking a forced release.

Function
REQ-010 The block SHALL have two states, IDLE (g=0) and GRANTED (g one-hot, owner latched).
REQ-011 In IDLE with r!=0, the block SHALL, at the next edge, enter GRANTED and grant the first set r bit, searching ptr, ptr+1, ... AGENTS-1, 0, ... ptr-1.
REQ-012 In IDLE with r=0, the block SHALL stay in IDLE with g=0.
REQ-013 Grant latency SHALL be one cycle: a request sampled at edge N gives g valid after edge N.
REQ-014 The block SHALL keep a hold count of the cycles g has been asserted for the current owner; it is 1 in the first grant cycle and is $clog2(MAX_HOLD+1) bits wide.
REQ-015 In GRANTED, the block SHALL release at the next edge when done[owner]=1, or r[owner]=0, or count==MAX_HOLD.
REQ-016 On release, the block SHALL return to IDLE (g=0 for at least one cycle) and set ptr=(owner+1) mod AGENTS, wrapping AGENTS-1 to 0.
REQ-017 The block SHALL raise timeout for exactly the first IDLE cycle after a release caused only by count==MAX_HOLD; it SHALL NOT raise timeout when done[owner] or a dropped request coincides with the limit.
REQ-018 While in GRANTED, the block SHALL ignore done and r bits of non-owners.
REQ-019 While in GRANTED, the block SHALL NOT move g to another agent; no preemption.
REQ-020 The block SHALL keep g one-hot or zero in every cycle, and busy SHALL equal |g.
REQ-021 A single requester SHALL be re-granted after the one-cycle IDLE gap, even though ptr has advanced past it.

Reset
REQ-022 With reset=1 at an edge, the block SHALL set g=0, busy=0, timeout=0, state=IDLE, ptr=0 and count=0, regardless of r and done.
REQ-023 When reset is asserted mid-grant, the block SHALL drop g at that edge, raise no timeout, and start arbitration from agent 0 after reset deasserts.
REQ-024 Reset SHALL take priority over every other event in the same cycle.

Verification (AGENTS=4, MAX_HOLD=4)
REQ-025 The bench SHALL cover reset held 2 cycles with r=1111, done=1111 -> g=0000, busy=0, timeout=0 each cycle.
REQ-026 The bench SHALL cover r=1111 held, with done[owner] pulsed in each owner's first grant cycle -> g sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-027 The bench SHALL cover r=0100 held, with done[2] pulsed in the 3rd grant cycle -> g=0100 for 3 cycles, 0000 for 1 cycle, then 0100 again with no timeout.
REQ-028 The bench SHALL cover r=0010 held with done=0 -> g=0010 for exactly 4 cycles, then g=0000 with timeout=1 for 1 cycle, then g=0010 again.
REQ-029 The bench SHALL cover owner 1 holding the grant while done=1101 is pulsed and r[1] is dropped in the next cycle -> g stays 0010 during the done pulse, goes 0000 after r[1] drops, and timeout stays 0.
REQ-030 The bench SHALL cover reset applied while g=1000, then r=1001 -> g=0000 after the reset edge, and the first grant after reset is 0001.
